// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - two-requester round-robin front end for one shared inequality comparator
//
// Purpose:
//   Two requesters share a single WIDTH-bit "operands differ" comparator.
//   A round-robin grant picks one requester in IDLE and captures its operands.
//   EXEC evaluates the XOR/OR-reduce and registers the result.
//   RESP holds the result until the owning consumer accepts it.
//   cmp_count wraps and counts completed result handshakes.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   [1:0] request valid, bit i = requester i
//   in_a0/in_b0, in_a1/in_b1  [WIDTH-1:0] operands of requester 0 / 1
//   in_ready   [1:0] request accept (one-hot or zero, IDLE only)
//   out_valid  [1:0] result valid for the owner (one-hot or zero)
//   out_ne     result, 1 = operands differ
//   out_ready  [1:0] consumer ready, only the owner's bit is observed
//   busy       state is not IDLE
//   cmp_count  [CNT_W-1:0] completed compares, wrapping
module cmp_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_a0,
  input  logic [WIDTH-1:0] in_b0,
  input  logic [WIDTH-1:0] in_a1,
  input  logic [WIDTH-1:0] in_b1,
  output logic [1:0]       in_ready,
  output logic [1:0]       out_valid,
  output logic             out_ne,
  input  logic [1:0]       out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cmp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  // On a tie the requester that did not finish last wins; otherwise the
  // single valid requester is chosen. With nothing valid, grant is unused.
  always_comb begin
    grant = 1'b0;
    if (in_valid == 2'b11) begin
      grant = ~last;
    end else begin
      grant = in_valid[1];
    end
  end

  // in_ready depends only on state, in_valid and last, so there is no
  // same-cycle path from out_ready.
  always_comb begin
    in_ready = 2'b00;
    if (state == IDLE) begin
      in_ready = {grant, ~grant} & in_valid;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 2'b00;
      out_ne    <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      cmp_count <= '0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_ready) begin
            owner <= grant;
            op_a  <= grant ? in_a1 : in_a0;
            op_b  <= grant ? in_b1 : in_b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          out_ne    <= |(op_a ^ op_b);
          out_valid <= {owner, ~owner};
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's consumer can retire the result.
          if (out_ready[owner]) begin
            last      <= owner;
            cmp_count <= cmp_count + 1'b1;
            out_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - self-checking bench for cmp_share_arbiter
module tb_cmp_share_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  in_valid;
  logic [31:0] in_a0, in_b0, in_a1, in_b1;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic        out_ne;
  logic [1:0]  out_ready;
  logic        busy;
  logic [3:0]  cmp_count;

  int total = 0;
  int bad   = 0;

  cmp_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_a0     (in_a0),
    .in_b0     (in_b0),
    .in_a1     (in_a1),
    .in_b1     (in_b1),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ne    (out_ne),
    .out_ready (out_ready),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model and scoreboard, evaluated on the falling edge.
  typedef struct {
    logic owner;
    logic ne;
  } exp_t;

  exp_t       q[$];
  int         m_state = 0;   // 0 idle, 1 exec, 2 resp
  logic       m_last  = 1'b1;
  logic [3:0] m_count = 4'd0;
  logic       armed   = 1'b0;

  function automatic logic m_grant(input logic [1:0] v, input logic lst);
    if (v == 2'b11) return !lst;
    return v[1];
  endfunction

  always @(negedge clock) begin
    logic       g;
    logic [1:0] exp_rdy;
    logic [1:0] exp_ov;
    exp_t       e;
    if (armed) begin
      g       = m_grant(in_valid, m_last);
      exp_rdy = (m_state == 0 && in_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
      exp_ov  = (m_state == 2) ? (q[0].owner ? 2'b10 : 2'b01) : 2'b00;
      chk("mon_busy", 32'(busy), 32'(m_state != 0));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_ov));
      if (m_state == 2) chk("mon_out_ne", 32'(out_ne), 32'(q[0].ne));
      chk("mon_cmp_count", 32'(cmp_count), 32'(m_count));
    end
    if (reset) begin
      m_state = 0;
      m_last  = 1'b1;
      m_count = 4'd0;
      q.delete();
      armed   = 1'b1;
    end else begin
      case (m_state)
        0: if (in_valid != 2'b00) begin
          g       = m_grant(in_valid, m_last);
          e.owner = g;
          e.ne    = g ? (in_a1 != in_b1) : (in_a0 != in_b0);
          q.push_back(e);
          m_state = 1;
        end
        1: m_state = 2;
        default: if (out_ready[q[0].owner]) begin
          m_last  = q[0].owner;
          m_count = m_count + 4'd1;
          void'(q.pop_front());
          m_state = 0;
        end
      endcase
    end
  end

  // One isolated request from requester r, result accepted right away.
  task automatic single(input int r, input logic [31:0] a, input logic [31:0] b, input logic ne);
    if (r == 0) begin
      in_a0 = a; in_b0 = b; in_valid = 2'b01;
    end else begin
      in_a1 = a; in_b1 = b; in_valid = 2'b10;
    end
    #1;
    chk("single_ready", 32'(in_ready), (r == 0) ? 32'd1 : 32'd2);
    tick();
    // Disturb inputs after accept; the result must not change.
    in_valid = 2'b00;
    in_a0 = ~in_a0; in_b0 = in_b0 + 32'd1;
    in_a1 = ~in_a1; in_b1 = in_b1 + 32'd1;
    chk("single_exec_busy", 32'(busy), 32'd1);
    chk("single_exec_ov", 32'(out_valid), 32'd0);
    tick();
    chk("single_resp_ov", 32'(out_valid), (r == 0) ? 32'd1 : 32'd2);
    chk("single_resp_ne", 32'(out_ne), 32'(ne));
    out_ready = (r == 0) ? 2'b01 : 2'b10;
    tick();
    out_ready = 2'b00;
    chk("single_done_ov", 32'(out_valid), 32'd0);
    chk("single_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 2'b00; out_ready = 2'b00;
    in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and idle hold.
    chk("rst_out_ne", 32'(out_ne), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_count", 32'(cmp_count), 32'd0);
    end

    // Single requester, equal then unequal (MSB-only difference).
    single(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    single(0, 32'h00000000, 32'h80000000, 1'b1);
    chk("single_count", 32'(cmp_count), 32'd2);

    // Round-robin from a fresh reset: last=1 so requester 0 goes first.
    reset = 1'b1; tick(); reset = 1'b0;
    in_a0 = 32'd5; in_b0 = 32'd6; in_a1 = 32'd1; in_b1 = 32'd1;
    in_valid = 2'b11; out_ready = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (out_valid != 2'b00) begin
        chk("rr_owner", 32'(out_valid), (n % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_ne", 32'(out_ne), (n % 2 == 0) ? 32'd1 : 32'd0);
        n++;
        if (n == 4) in_valid = 2'b00;
      end
    end
    chk("rr_responses", 32'(n), 32'd4);
    tick();
    out_ready = 2'b00;
    chk("rr_count", 32'(cmp_count), 32'd4);
    chk("rr_idle", 32'(busy), 32'd0);

    // Backpressure on requester 1; non-owner ready and requests are ignored.
    in_a1 = 32'h0F; in_b1 = 32'hF0; in_valid = 2'b10;
    tick();
    in_valid = 2'b00;
    tick();
    in_valid = 2'b01; out_ready = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd2);
      chk("bp_out_ne", 32'(out_ne), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    in_valid = 2'b00; out_ready = 2'b10;
    tick();
    out_ready = 2'b00;
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_count", 32'(cmp_count), 32'd5);

    // Reset during EXEC.
    in_a0 = 32'd1; in_b0 = 32'd2; in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    chk("rx_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rx_exec_busy_after", 32'(busy), 32'd0);
    chk("rx_exec_ov_after", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rx_exec_no_resp", 32'(out_valid), 32'd0);
    end

    // Reset during RESP.
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    tick();
    chk("rx_resp_ov", 32'(out_valid), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rx_resp_ov_after", 32'(out_valid), 32'd0);
    chk("rx_resp_busy_after", 32'(busy), 32'd0);
    chk("rx_resp_count", 32'(cmp_count), 32'd0);

    // Requester 1 alone is granted straight away after reset.
    in_a1 = 32'd7; in_b1 = 32'd7; in_valid = 2'b10;
    #1;
    chk("rx_req1_ready", 32'(in_ready), 32'd2);
    single(1, 32'd7, 32'd7, 1'b0);
    chk("rx_req1_count", 32'(cmp_count), 32'd1);

    // Counter wrap with a 4-bit counter: 17 compares read back as 1.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      single(i % 2, 32'(i), (i % 2 == 1) ? 32'(i + 1) : 32'(i), (i % 2 == 1));
    end
    chk("wrap_count", 32'(cmp_count), 32'd1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
